simple_uart_wb: RTL and testbench
=================================

// Module: simple_uart_wb
// PURPOSE
//  Wishbone-slave-wrapped 8N1 UART: programmable 32-bit baud divider plus a data register.
//  Writes to DATA transmit a byte on ser_tx; reads return the last received byte or all-ones.
//  Sits on the management SoC Wishbone bus as a peripheral at BASE_ADR.
// PARAMETERS
//  BASE_ADR  32'h2000_0000  peripheral base; register address = BASE_ADR | offset
//  CLK_DIV   8'h00          offset of divider register
//  DATA      8'h04          offset of data register
// PORTS
//  wb_clk_i  in   1   bus/UART clock; single clock domain
//  wb_rst_i  in   1   reset, asynchronous, active-low (asserted when 0)
//  wb_stb_i  in   1   strobe
//  wb_cyc_i  in   1   bus cycle
//  wb_we_i   in   1   1=write, 0=read
//  wb_sel_i  in   4   byte lane enables
//  wb_adr_i  in   32  byte address
//  wb_dat_i  in   32  write data
//  wb_ack_o  out  1   transfer acknowledge
//  wb_dat_o  out  32  read data
//  ser_tx    out  1   serial transmit (idle high)
//  ser_rx    in   1   serial receive (idle high)
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_dat_o=0, ser_tx=1, divider=32'd1, TX idle, RX idle, rx_valid=0.
//  Request = stb & cyc & (adr == BASE_ADR|CLK_DIV or BASE_ADR|DATA); other addresses never ack.
//  Ack: registered; rises on edge sampling request with ack=0; single-cycle pulse (ack<=req&~ack).
//  Write/read commit on the same edge ack rises; wb_dat_o loaded then, held until next read ack.
//  CLK_DIV write: per-byte update via wb_sel_i; read returns full 32-bit divider.
//  DATA write with sel[0]=1: if TX idle -> load wb_dat_i[7:0], start frame, ack; if TX busy ->
//   ack withheld (stall) until TX idle, then commit. sel[0]=0 -> ack, no effect.
//  DATA read: rx_valid ? {24'h0, rx_byte} : 32'hFFFF_FFFF; ack clears rx_valid.
//  TX frame: start(0), 8 data LSB first, stop(1); each bit DIV+1 clocks (counter 0..DIV,
//   32-bit, compare not add, so DIV=FFFF_FFFF is legal); back to idle high after stop.
//  RX: falling edge on ser_rx while idle starts; sample at DIV/2 into start bit (abort if high),
//   then each bit at DIV+1 spacing; stop sampled then byte stored, rx_valid=1; new byte
//   overwrites unread one (overrun silent). RX same-cycle with DATA read: new byte wins, valid=1.
//  Divider changed mid-frame: takes effect at next bit boundary.
//  Reset mid-frame: everything returns to reset state immediately.
// CONFIGURATION
//  UART_RX_EN defined: receiver built as above.
//  UART_RX_EN undefined: no receiver; ser_rx ignored; DATA read always 32'hFFFF_FFFF.
// STRUCTURE
//  simple_uart_pkg: register offsets, reset divider constant, frame bit count (10).
//  Sub-module simple_uart_core: divider, TX/RX shifters, byte-level reg interface
//   (div_we[3:0], dat_we, dat_re, dat_wait, rx byte/valid); wrapper does Wishbone decode/ack.
// TESTING
//  Reset then read CLK_DIV -> 32'h0000_0001, ser_tx=1, single-cycle ack.
//  Write CLK_DIV=FFFF_FFFF sel=F, read back -> FFFF_FFFF; sel=4'h1 write 0x12 -> FFFF_FF12.
//  Write DATA=FFFF_FFFF (TX idle) -> ack, ser_tx start bit; read DATA (no rx) -> FFFF_FFFF.
//  DIV=3, write DATA 0xA5 -> ser_tx 0,1,0,1,0,0,1,0,1,1 each 4 clocks; 2nd write stalls to idle.
//  UART_RX_EN, DIV=3, drive 0x3C frame on ser_rx -> DATA read 0000_003C, next read FFFF_FFFF.
//  Access BASE_ADR|0x10 -> no ack; async reset mid-TX -> ser_tx=1, divider=1 immediately.

Source files
------------

// File: rtl/simple_uart_pkg.sv
// Package: simple_uart_pkg
// Purpose: shared constants and types for the Wishbone-wrapped 8N1 UART.
//   Register offsets, reset divider value, serial frame length, FSM state
//   types and the register address helper.
package simple_uart_pkg;

  localparam logic [31:0] DEF_BASE_ADR = 32'h2000_0000;
  localparam logic [7:0]  REG_CLK_DIV  = 8'h00;
  localparam logic [7:0]  REG_DATA     = 8'h04;
  localparam logic [31:0] RESET_DIV    = 32'd1;
  // start + 8 data + stop
  localparam int          FRAME_BITS   = 10;

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] ofs);
    return base | {24'h0, ofs};
  endfunction

endpackage

// File: rtl/simple_uart_core.sv
// Module: simple_uart_core
// Purpose: 32-bit baud divider, 8N1 transmitter and (optionally) receiver with a
//   byte-level register interface. Each serial bit lasts div+1 clocks; the
//   divider is latched at every bit boundary, so a divider write made mid-frame
//   takes effect from the next bit.
// Configuration: macro UART_RX_EN builds the receiver; without it ser_rx is
//   ignored and rx_valid stays 0.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wdata            write data from the bus
//   div_we[3:0]      per-byte divider write enables
//   dat_we           load wdata[7:0] into the transmitter (only while idle)
//   dat_re           data register read; clears rx_valid
//   div              current divider value
//   dat_wait         transmitter busy; a data write must wait
//   rx_byte/rx_valid last received byte and its valid flag
//   ser_tx / ser_rx  serial lines, idle high
module simple_uart_core
  import simple_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wdata,
  input  logic [3:0]  div_we,
  input  logic        dat_we,
  input  logic        dat_re,
  output logic [31:0] div,
  output logic        dat_wait,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        ser_tx,
  input  logic        ser_rx
);

  // ---------------- divider ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= RESET_DIV;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (div_we[i]) div[8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t   tx_state;
  logic [8:0]  tx_shift;  // remaining bits, LSB next; stop bit at the top
  logic [3:0]  tx_bit;    // index of the bit currently on ser_tx
  logic [31:0] tx_cnt;
  logic [31:0] tx_div;    // divider latched for the current bit

  assign dat_wait = (tx_state == TX_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      ser_tx   <= 1'b1;
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      tx_div   <= RESET_DIV;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (dat_we) begin
            tx_state <= TX_BUSY;
            ser_tx   <= 1'b0;
            tx_shift <= {1'b1, wdata[7:0]};
            tx_bit   <= '0;
            tx_cnt   <= '0;
            tx_div   <= div;
          end
        end
        TX_BUSY: begin
          // equality compare, so div = all-ones never overflows the counter
          if (tx_cnt == tx_div) begin
            tx_cnt <= '0;
            tx_div <= div;
            if (tx_bit == 4'(FRAME_BITS - 1)) begin
              tx_state <= TX_IDLE;
              ser_tx   <= 1'b1;
            end else begin
              ser_tx   <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              tx_bit   <= tx_bit + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 32'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
`ifdef UART_RX_EN
  rx_state_t   rx_state;
  logic [2:0]  rx_sync;   // [1] is the synchronised line, [2] its previous value
  logic [31:0] rx_cnt;
  logic [31:0] rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_in;
  logic        rx_fall;

  assign rx_in   = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= '1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= RESET_DIV;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], ser_rx};
      // a byte stored below on this same edge overrides the clear
      if (dat_re) rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
            rx_div   <= div;
          end
        end
        RX_START: begin
          if (rx_cnt == (rx_div >> 1)) begin
            rx_cnt   <= '0;
            rx_div   <= div;
            rx_bit   <= '0;
            // line back high at mid start bit: a glitch, not a frame
            rx_state <= rx_in ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == rx_div) begin
            rx_cnt   <= '0;
            rx_div   <= div;
            rx_shift <= {rx_in, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == rx_div) begin
            rx_state <= RX_IDLE;
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
`else
  logic rx_unused;
  assign rx_unused = ser_rx ^ dat_re;
  assign rx_byte   = 8'h00;
  assign rx_valid  = 1'b0;
`endif

endmodule

// File: rtl/simple_uart_wb.sv
// Module: simple_uart_wb
// Purpose: Wishbone slave wrapper around simple_uart_core. Decodes the divider
//   (BASE_ADR|CLK_DIV) and data (BASE_ADR|DATA) registers and generates a
//   registered single-cycle ack. Handshake: a request is stb & cyc & a decoded
//   address; the access commits on the edge where ack rises, and ack is
//   withheld while a data write finds the transmitter busy.
// Configuration: macro UART_RX_EN enables the receiver; otherwise DATA reads
//   return 32'hFFFF_FFFF.
// Ports:
//   wb_clk_i, wb_rst_i (async, active-low), wb_stb_i, wb_cyc_i, wb_we_i,
//   wb_sel_i[3:0], wb_adr_i[31:0], wb_dat_i[31:0], wb_ack_o, wb_dat_o[31:0],
//   ser_tx, ser_rx
module simple_uart_wb
  import simple_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = DEF_BASE_ADR,
  parameter logic [7:0]  CLK_DIV  = REG_CLK_DIV,
  parameter logic [7:0]  DATA     = REG_DATA
)(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        ser_tx,
  input  logic        ser_rx
);

  logic        hit_div, hit_dat, req, stall, commit;
  logic [3:0]  div_we;
  logic        dat_we, dat_re, dat_wait, rx_valid;
  logic [31:0] div;
  logic [7:0]  rx_byte;

  assign hit_div = (wb_adr_i == reg_addr(BASE_ADR, CLK_DIV));
  assign hit_dat = (wb_adr_i == reg_addr(BASE_ADR, DATA));
  assign req     = wb_stb_i & wb_cyc_i & (hit_div | hit_dat);
  assign stall   = hit_dat & wb_we_i & wb_sel_i[0] & dat_wait;
  assign commit  = req & ~wb_ack_o & ~stall;

  assign div_we = (commit & wb_we_i & hit_div) ? wb_sel_i : 4'h0;
  assign dat_we = commit & wb_we_i & hit_dat & wb_sel_i[0];
  assign dat_re = commit & ~wb_we_i & hit_dat;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= commit;
      if (commit & ~wb_we_i) begin
        if (hit_div)       wb_dat_o <= div;
        else if (rx_valid) wb_dat_o <= {24'h0, rx_byte};
        else               wb_dat_o <= '1;
      end
    end
  end

  simple_uart_core u_core (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .wdata    (wb_dat_i),
    .div_we   (div_we),
    .dat_we   (dat_we),
    .dat_re   (dat_re),
    .div      (div),
    .dat_wait (dat_wait),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .ser_tx   (ser_tx),
    .ser_rx   (ser_rx)
  );

endmodule

// File: tb/tb_simple_uart_wb.sv
// Testbench for simple_uart_wb: directed register/bus steps plus randomized
// TX frames and divider writes, checked against a behavioural model of the
// register file and the serial frame format.
module tb_simple_uart_wb;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam logic [31:0] A_DIV = BASE | 32'h00;
  localparam logic [31:0] A_DAT = BASE | 32'h04;
`ifdef UART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_i = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        ser_tx;
  logic        ser_rx = 1'b1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] div_m;            // model of the divider register
  logic        rx_valid_m = 1'b0;
  logic [7:0]  rx_byte_m = 8'h00;
  logic [31:0] exp_q[$];         // expected ser_tx value, one entry per clock

  simple_uart_wb dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_we_i  (we),
    .wb_sel_i (sel),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_ack_o (ack),
    .wb_dat_o (dat_o),
    .ser_tx   (ser_tx),
    .ser_rx   (ser_rx)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int budget,
                         output logic got, output logic [31:0] rd, output int lat);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    got = 1'b0; rd = '0; lat = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #1;
      lat = i + 1;
      if (ack) begin
        got = 1'b1;
        rd  = dat_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input string tag, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    logic got; logic [31:0] rd; int lat;
    wb_xfer(1'b1, a, s, d, 2000, got, rd, lat);
    check({tag, "_ack"}, {31'b0, got}, 32'd1);
    if (a == A_DIV) begin
      for (int i = 0; i < 4; i++) if (s[i]) div_m[8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic got; logic [31:0] rd; int lat;
    wb_xfer(1'b0, a, 4'hF, 32'h0, 50, got, rd, lat);
    check({tag, "_ack"}, {31'b0, got}, 32'd1);
    check(tag, rd, exp);
  endtask

  // expected DATA read result from the receive model; a read consumes the byte
  function automatic logic [31:0] rx_read_exp();
    logic [31:0] e;
    e = (RX_EN && rx_valid_m) ? {24'h0, rx_byte_m} : 32'hFFFF_FFFF;
    rx_valid_m = 1'b0;
    return e;
  endfunction

  // Called right after the ack of a DATA write: the frame starts on that edge.
  task automatic tx_expect(input string tag, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (longint k = 0; k <= longint'(div_m); k++) exp_q.push_back({31'b0, frame[j]});
    end
    while (exp_q.size() > 0) begin
      check(tag, {31'b0, ser_tx}, exp_q.pop_front());
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check({tag, "_idle"}, {31'b0, ser_tx}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    @(posedge clk); #1;
    for (int j = 0; j < 10; j++) begin
      ser_rx = frame[j];
      for (longint k = 0; k <= longint'(div_m); k++) @(posedge clk);
      #1;
    end
    ser_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_valid_m = 1'b1;
    rx_byte_m  = b;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic got; logic [31:0] rd; int lat;
    logic [7:0] b, b2;
    logic [31:0] d;
    logic [3:0] s;

    // reset
    div_m = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_tx", {31'b0, ser_tx}, 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // reset divider read, single-cycle ack
    bus_read("div_rst", A_DIV, 32'h0000_0001);
    @(posedge clk); #1;
    check("ack_pulse", {31'b0, ack}, 32'd0);

    // full and per-byte divider writes
    bus_write("div_ff", A_DIV, 4'hF, 32'hFFFF_FFFF);
    bus_read("div_ff_rd", A_DIV, div_m);
    check("div_ff_val", div_m, 32'hFFFF_FFFF);
    bus_write("div_b0", A_DIV, 4'h1, 32'h0000_0012);
    bus_read("div_b0_rd", A_DIV, 32'hFFFF_FF12);

    // transmit with a huge divider, then reset in the middle of the frame
    bus_write("tx_long", A_DAT, 4'h1, 32'hFFFF_FFFF);
    check("tx_long_start", {31'b0, ser_tx}, 32'd0);
    bus_read("dat_norx", A_DAT, rx_read_exp());
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'b0, ser_tx}, 32'd1);
    check("async_rst_ack", {31'b0, ack}, 32'd0);
    check("async_rst_dat", dat_o, 32'd0);
    div_m = 32'd1;
    rx_valid_m = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    bus_read("div_after_rst", A_DIV, div_m);

    // randomized byte-lane divider writes
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      bus_write("div_rand", A_DIV, s, d);
      bus_read("div_rand_rd", A_DIV, div_m);
    end

    // DIV=3: 0xA5 frame
    bus_write("div3", A_DIV, 4'hF, 32'd3);
    bus_write("tx_a5", A_DAT, 4'h1, 32'h0000_00A5);
    tx_expect("tx_a5_bit", 8'hA5);

    // back-to-back writes: the second stalls until the first frame is done
    b  = 8'($urandom);
    b2 = 8'($urandom);
    bus_write("tx_first", A_DAT, 4'h1, {24'h0, b});
    wb_xfer(1'b1, A_DAT, 4'h1, {24'h0, b2}, 200, got, rd, lat);
    check("stall_ack", {31'b0, got}, 32'd1);
    check("stall_min", {31'b0, (lat >= 10 * (int'(div_m) + 1))}, 32'd1);
    check("stall_max", {31'b0, (lat <= 10 * (int'(div_m) + 1) + 2)}, 32'd1);
    tx_expect("tx_second_bit", b2);

    // randomized frames with random small dividers
    for (int i = 0; i < 4; i++) begin
      bus_write("div_small", A_DIV, 4'hF, 32'($urandom_range(0, 4)));
      b = 8'($urandom);
      bus_write("tx_rand", A_DAT, 4'h1, {24'h0, b});
      tx_expect("tx_rand_bit", b);
    end

    // DATA write with sel[0]=0: acked, no frame
    bus_write("tx_nosel", A_DAT, 4'hE, 32'h0000_0000);
    for (int i = 0; i < 6; i++) begin
      check("tx_nosel_idle", {31'b0, ser_tx}, 32'd1);
      @(posedge clk); #1;
    end

    // unmapped addresses never ack
    wb_xfer(1'b0, BASE | 32'h10, 4'hF, 32'h0, 20, got, rd, lat);
    check("noack_10", {31'b0, got}, 32'd0);
    wb_xfer(1'b1, 32'h3000_0004, 4'h1, 32'h55, 20, got, rd, lat);
    check("noack_base", {31'b0, got}, 32'd0);
    check("noack_tx", {31'b0, ser_tx}, 32'd1);

    // receive path (read-back depends on whether the receiver is built)
    bus_write("div3_rx", A_DIV, 4'hF, 32'd3);
    send_rx(8'h3C);
    bus_read("rx_3c", A_DAT, rx_read_exp());
    bus_read("rx_empty", A_DAT, rx_read_exp());
    b  = 8'($urandom);
    b2 = 8'($urandom);
    send_rx(b);
    send_rx(b2);
    bus_read("rx_overrun", A_DAT, rx_read_exp());
    // one-clock low glitch must not produce a byte
    @(posedge clk); #1 ser_rx = 1'b0;
    @(posedge clk); #1 ser_rx = 1'b1;
    repeat (20) @(posedge clk);
    bus_read("rx_glitch", A_DAT, rx_read_exp());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
